// File: rtl/clk_monitor_if.sv
// Status/measurement bundle between a clk_monitor and its consumer.
// Carries per_min/per_max only when MON_HIST_EN is defined.
interface clk_monitor_if #(
  parameter int W = 8
) ();
  logic         mon_clk;
  logic         err_clr;
  logic [W-1:0] period;
  logic         period_vld;
  logic         locked;
  logic         stuck;
  logic [7:0]   err_cnt;
`ifdef MON_HIST_EN
  logic [W-1:0] per_min;
  logic [W-1:0] per_max;

  modport master (
    output mon_clk, err_clr,
    input  period, period_vld, locked, stuck, err_cnt, per_min, per_max
  );
  modport slave (
    input  mon_clk, err_clr,
    output period, period_vld, locked, stuck, err_cnt, per_min, per_max
  );
`else
  modport master (
    output mon_clk, err_clr,
    input  period, period_vld, locked, stuck, err_cnt
  );
  modport slave (
    input  mon_clk, err_clr,
    output period, period_vld, locked, stuck, err_cnt
  );
`endif
endinterface

// File: rtl/clk_monitor.sv
// Measures a divided clock's period against clk_in, tracks lock, flags a stuck clock, counts errors.
// Optional MON_HIST_EN adds per_min/per_max period history.
module clk_monitor #(
  parameter int W          = 8,
  parameter int EXP_PERIOD = 12,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk_in,
  input  logic        ar,
  clk_monitor_if.slave mon
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  // Tolerance window in W+1 bits so EXP_PERIOD+TOL cannot wrap
  localparam logic [W:0]    LO      = (EXP_PERIOD > TOL) ? (W+1)'(EXP_PERIOD - TOL) : '0;
  localparam logic [W:0]    HI      = (W+1)'(EXP_PERIOD + TOL);
  localparam logic [W-1:0]  CNT_MAX = '1;
  localparam logic [W-1:0]  TO      = W'(TIMEOUT);
  localparam logic [GW:0]   LC      = (GW+1)'(LOCK_CNT);

  logic          s1, s2, s3;
  logic [W-1:0]  cnt;
  logic [W-1:0]  period_q;
  logic          vld_q, locked_q, stuck_q;
  logic [7:0]    err_q;
  logic [1:0]    state, state_nx;
  logic [GW-1:0] gc, gc_nx;
  logic [GW:0]   gc_inc;
  logic          rise, good, measure, timeout, err_ev;

  assign rise    = s2 & ~s3;
  assign good    = ({1'b0, cnt} >= LO) && ({1'b0, cnt} <= HI);
  assign measure = rise && (state != IDLE);
  assign timeout = !rise && (state != IDLE) && (cnt == TO);
  assign err_ev  = (measure && !good && (state == LOCKED || state == FAULT)) || timeout;
  assign gc_inc  = {1'b0, gc} + 1'b1;

  always_comb begin
    state_nx = state;
    gc_nx    = gc;
    if (rise) begin
      case (state)
        IDLE: begin
          state_nx = ACQ;
          gc_nx    = '0;
        end
        ACQ: begin
          if (!good)             gc_nx = '0;
          else if (gc_inc >= LC) state_nx = LOCKED;
          else                   gc_nx = gc_inc[GW-1:0];
        end
        LOCKED: if (!good) state_nx = FAULT;
        FAULT: if (good) begin
          state_nx = ACQ;
          gc_nx    = GW'(1);
        end
        default: state_nx = IDLE;
      endcase
    end else if (timeout) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      cnt      <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
      err_q    <= '0;
      state    <= IDLE;
      gc       <= '0;
    end else begin
      s1       <= mon.mon_clk;
      s2       <= s1;
      s3       <= s2;
      state    <= state_nx;
      gc       <= gc_nx;
      locked_q <= (state_nx == LOCKED);
      vld_q    <= measure;
      if (measure) period_q <= cnt;
      if (rise)                cnt <= W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (rise)         stuck_q <= 1'b0;
      else if (timeout) stuck_q <= 1'b1;
      // Clear beats a coincident error event
      if (mon.err_clr)                   err_q <= '0;
      else if (err_ev && err_q != 8'hFF) err_q <= err_q + 1'b1;
    end
  end

  assign mon.period     = period_q;
  assign mon.period_vld = vld_q;
  assign mon.locked     = locked_q;
  assign mon.stuck      = stuck_q;
  assign mon.err_cnt    = err_q;

`ifdef MON_HIST_EN
  logic [W-1:0] min_q, max_q;

  always_ff @(posedge clk_in or negedge ar) begin
    if (!ar) begin
      min_q <= '1;
      max_q <= '0;
    end else if (mon.err_clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (measure) begin
      if (cnt < min_q) min_q <= cnt;
      if (cnt > max_q) max_q <= cnt;
    end
  end

  assign mon.per_min = min_q;
  assign mon.per_max = max_q;
`endif
endmodule
